// File: rtl/score_display.sv
// score_display: renders an N-digit decimal score as scaled ROM glyphs with a frame-coherent BCD display register
module score_display #(
  parameter int DIGITS = 3,
  parameter int SCORE_W = 10,
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 11,
  parameter int SCALE_LOG2 = 1,
  parameter int X0 = 16,
  parameter int Y0 = 16,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter int LZB = 1
) (
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [SCORE_W-1:0] score,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               digit_on,
  output logic               busy
);
  localparam int GW_LOG2 = $clog2(GLYPH_W);
  localparam int ROM_N = GLYPH_H * 10 * GLYPH_W;
  localparam int AW = $clog2(ROM_N);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W = BCD_W + SCORE_W;
  localparam int CW = $clog2(SCORE_W + 1);
  localparam int BOX_W = (DIGITS * GLYPH_W) << SCALE_LOG2;
  localparam int BOX_H = GLYPH_H << SCALE_LOG2;
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};
  localparam logic [879:0] FONT = {
    88'h003C66666E76666666_3C00, 88'h00183818181818181_87E00,
    88'h003C66060C18306066_7E00, 88'h003C66061C06060666_3C00,
    88'h000C1C3C6CCCFE0C0C_1E00, 88'h007E60607C06060666_3C00,
    88'h001C30607C66666666_3C00, 88'h007E66060C18181818_1800,
    88'h003C66663C66666666_3C00, 88'h003C6666663E06060C_3800
  };

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [ROM_N-1:0] build_rom();
    logic [ROM_N-1:0] r;
    r = '0;
    for (int y = 0; y < GLYPH_H && y < 11; y++)
      for (int d = 0; d < 10; d++)
        for (int c = 0; c < GLYPH_W; c++)
          r[y*10*GLYPH_W + d*GLYPH_W + c] = FONT[879 - 8*(d*11 + y) - (c*8)/GLYPH_W];
    return r;
  endfunction

  localparam longint MAX_V = pow10(DIGITS) - 1;
  localparam logic [ROM_N-1:0] ROM = build_rom();

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t state_q, state_d;
  logic [SH_W-1:0] sh_q, sh_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d, busy_q, busy_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [9:0] rel_x, rel_y, d_idx;
  logic in_box_d, dblank_d, run;
  logic [3:0] dig;
  logic [AW-1:0] addr_d;
  logic rom_q, in_box_q, dblank_q, blank_q, on_d, on_q;
  logic [11:0] rgb_q;

  // double-dabble conversion sequencing and display register load
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    bcd_d = bcd_q;
    busy_d = busy_q;
    adj = sh_q;
    for (int i = 0; i < DIGITS; i++)
      adj[SCORE_W + 4*i +: 4] = sh_q[SCORE_W + 4*i +: 4] >= 4'd5 ? sh_q[SCORE_W + 4*i +: 4] + 4'd3 : sh_q[SCORE_W + 4*i +: 4];
    if (state_q == IDLE && frame_start) begin
      state_d = CONV;
      sh_d = SH_W'(score);
      cnt_d = '0;
      sat_d = 64'(score) > MAX_V;
      busy_d = 1'b1;
    end else if (state_q == CONV) begin
      sh_d = adj << 1;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(SCORE_W - 1) ? LOAD : CONV;
    end else if (state_q == LOAD) begin
      bcd_d = sat_q ? NINES : sh_q[SH_W-1 -: BCD_W];
      busy_d = 1'b0;
      state_d = IDLE;
    end
  end

  // converter state; reset aborts any conversion and clears the display
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      bcd_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      bcd_q <= bcd_d;
      busy_q <= busy_d;
    end
  end

  // stage 0: box test, digit select, leading-zero blank and glyph ROM address
  always_comb begin
    rel_x = DrawX - 10'(X0);
    rel_y = DrawY - 10'(Y0);
    in_box_d = 32'(DrawX) >= X0 && 32'(DrawY) >= Y0 && 32'(rel_x) < BOX_W && 32'(rel_y) < BOX_H;
    d_idx = rel_x >> (GW_LOG2 + SCALE_LOG2);
    run = 1'b1;
    dig = '0;
    dblank_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      run = run & (bcd_q[4*(DIGITS-1-i) +: 4] == 4'd0);
      if (32'(d_idx) == i) begin
        dig = bcd_q[4*(DIGITS-1-i) +: 4];
        dblank_d = (LZB != 0) && (i != DIGITS - 1) && run;
      end
    end
    addr_d = in_box_d ? AW'(32'(rel_y >> SCALE_LOG2) * 10 * GLYPH_W + 32'(dig) * GLYPH_W + 32'(rel_x >> SCALE_LOG2) % GLYPH_W) : '0;
  end

  assign on_d = in_box_q & rom_q & ~dblank_q & blank_q;

  // stage 1 holds the synchronous ROM read and delayed flags; stage 2 the colour outputs
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_q <= 1'b0;
      in_box_q <= 1'b0;
      dblank_q <= 1'b0;
      blank_q <= 1'b0;
      on_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      rom_q <= ROM[addr_d];
      in_box_q <= in_box_d;
      dblank_q <= dblank_d;
      blank_q <= blank;
      on_q <= on_d;
      rgb_q <= on_d ? FG_RGB : 12'h000;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign digit_on = on_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: randomized and directed checks of score_display against a behavioural pixel/score model
module tb_score_display;
  localparam int D = 3, SW = 10, GW = 8, SC = 2, X0 = 16, Y0 = 16;
  localparam int BOX_W = D * GW * SC, BOX_H = 11 * SC;
  localparam logic [7:0] FONT [10][11] = '{
    '{8'h00,8'h3C,8'h66,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h66,8'h3C,8'h00},
    '{8'h00,8'h18,8'h38,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00},
    '{8'h00,8'h3C,8'h66,8'h06,8'h0C,8'h18,8'h30,8'h60,8'h66,8'h7E,8'h00},
    '{8'h00,8'h3C,8'h66,8'h06,8'h1C,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00},
    '{8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h1E,8'h00},
    '{8'h00,8'h7E,8'h60,8'h60,8'h7C,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00},
    '{8'h00,8'h1C,8'h30,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00},
    '{8'h00,8'h7E,8'h66,8'h06,8'h0C,8'h18,8'h18,8'h18,8'h18,8'h18,8'h00},
    '{8'h00,8'h3C,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00},
    '{8'h00,8'h3C,8'h66,8'h66,8'h66,8'h3E,8'h06,8'h06,8'h0C,8'h38,8'h00}
  };

  logic clk = 0, Reset = 1, blank = 0, frame_start = 0;
  logic [9:0] DrawX = 0, DrawY = 0, score = 0;
  logic [3:0] r1, g1, b1, r0, g0, b0;
  logic on1, on0, busy1, busy0;
  int errs = 0, checks = 0, disp = 0, pend = 0, rem = 0;
  bit chk_en = 0, e1 = 0, e0 = 0, s1_1 = 0, s1_0 = 0, e_busy = 0;

  always #5 clk = ~clk;

  score_display #(.LZB(1)) dut (
    .vga_clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .score(score), .red(r1), .green(g1), .blue(b1),
    .digit_on(on1), .busy(busy1));

  score_display #(.LZB(0)) dut0 (
    .vga_clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .score(score), .red(r0), .green(g0), .blue(b0),
    .digit_on(on0), .busy(busy0));

  function automatic int p10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic bit pix(input int x, input int y, input bit bl, input int v, input bit lzb);
    int rx, ry, d, c, r, dv;
    logic [7:0] row_bits;
    if (!bl || x < X0 || y < Y0) return 0;
    rx = x - X0;
    ry = y - Y0;
    if (rx >= BOX_W || ry >= BOX_H) return 0;
    d = rx / (GW * SC);
    c = (rx / SC) % GW;
    r = ry / SC;
    if (lzb && d < D - 1 && v / p10(D - 1 - d) == 0) return 0;
    dv = (v / p10(D - 1 - d)) % 10;
    row_bits = FONT[dv][r];
    return row_bits[7 - c * 8 / GW];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (Reset) begin
      e1 = 0; e0 = 0; s1_1 = 0; s1_0 = 0; rem = 0; disp = 0;
    end else begin
      e1 = s1_1;
      e0 = s1_0;
      s1_1 = pix(DrawX, DrawY, blank, disp, 1);
      s1_0 = pix(DrawX, DrawY, blank, disp, 0);
      if (rem > 0) begin
        rem--;
        if (rem == 0) disp = pend;
      end else if (frame_start) begin
        pend = score > 999 ? 999 : int'(score);
        rem = SW + 1;
      end
    end
    e_busy = rem > 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_lzb1", busy1, e_busy);
      check("busy_lzb0", busy0, e_busy);
      check("on_lzb1", on1, e1);
      check("on_lzb0", on0, e0);
      check("rgb_lzb1", {r1, g1, b1}, e1 ? 12'hFFF : 12'h000);
      check("rgb_lzb0", {r0, g0, b0}, e0 ? 12'hFFF : 12'h000);
    end
  end

  task automatic probe(input int x, input int y, input bit bl, input bit ex1, input bit ex0, input string nm);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl;
    @(negedge clk);
    @(negedge clk);
    check({nm, "_lzb1"}, on1, ex1);
    check({nm, "_lzb0"}, on0, ex0);
  endtask

  task automatic convert(input string nm);
    int n;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    n = 0;
    while (busy1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(nm, n, 11);
  endtask

  task automatic scan();
    for (int y = Y0 - 2; y < Y0 + BOX_H + 2; y++)
      for (int x = X0 - 2; x < X0 + BOX_W + 2; x++) begin
        DrawX = 10'(x); DrawY = 10'(y); blank = ($urandom % 8) != 0;
        @(negedge clk);
      end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    Reset = 0;
    chk_en = 1;
    check("rst_busy", busy1, 0);
    check("rst_on", on1, 0);
    check("rst_rgb", {r1, g1, b1}, 0);
    scan();
    probe(52, 18, 1, 1, 1, "t1_d2_zero");
    probe(20, 18, 1, 0, 1, "t1_d0_lz");
    score = 10'd742;
    convert("t2_busy_len");
    scan();
    probe(18, 18, 1, 1, 1, "t2_d0_7on");
    probe(16, 18, 1, 0, 0, "t2_d0_7off");
    probe(32, 28, 1, 1, 1, "t2_d1_4");
    probe(58, 22, 1, 1, 1, "t2_d2_2on");
    probe(56, 22, 1, 0, 0, "t2_d2_2off");
    score = 10'd1000;
    convert("t3_busy_len");
    probe(20, 26, 1, 1, 1, "t3_sat9on");
    probe(18, 26, 1, 0, 0, "t3_sat9off");
    scan();
    score = 10'd5;
    convert("t4_busy_len");
    scan();
    probe(50, 18, 1, 1, 1, "t4_d2_5");
    probe(36, 18, 1, 0, 1, "t4_d1_lz");
    score = 10'd456;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    repeat (3) @(negedge clk);
    score = 10'd123;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    repeat (12) @(negedge clk);
    probe(16, 28, 1, 1, 1, "t5_orig456");
    convert("t5_busy_len");
    probe(16, 28, 1, 0, 0, "t5_new123");
    scan();
    score = 10'd888;
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    repeat (4) @(negedge clk);
    Reset = 1;
    @(negedge clk);
    Reset = 0;
    check("t6_busy_abort", busy1, 0);
    probe(52, 18, 1, 1, 1, "t6_d2_zero");
    probe(20, 18, 1, 0, 1, "t6_d0_cleared");
    probe(15, 18, 1, 0, 0, "t6_x_edge");
    probe(20, 15, 1, 0, 0, "t6_y_edge");
    probe(52, 18, 0, 0, 0, "t6_blank");
    repeat (4) begin
      score = 10'($urandom_range(0, 1023));
      convert("rnd_busy_len");
      for (int i = 0; i < 400; i++) begin
        DrawX = 10'($urandom_range(10, 70));
        DrawY = 10'($urandom_range(10, 45));
        blank = ($urandom % 8) != 0;
        frame_start = ($urandom % 60) == 0;
        if ($urandom % 30 == 0) score = 10'($urandom_range(0, 1023));
        @(negedge clk);
      end
      frame_start = 0;
      repeat (15) @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
